// File: rtl/defuzzifier_div.sv
// ---------------------------------------------------------------------------
// defuzzifier_div
//   Final defuzzification step: crisp = S_wg / S_w. It uses a restoring
//   divider that produces one quotient bit per cycle (16 bits, MSB first).
//   The quotient is rounded to Q1.15 and also converted to a 0..100 percent
//   value.
//
// Ports
//   clk     in   1  clock, rising edge
//   rst     in   1  asynchronous active-high reset
//   start   in   1  division request, sampled only in IDLE
//   S_w     in  16  sum of rule weights, Q1.15 unsigned
//   S_wg    in  16  weighted sum, Q1.15 unsigned
//   busy    out  1  division iterations in progress
//   done    out  1  one-cycle pulse; y_q15/y_pct/zero_w updated
//   y_q15   out 16  crisp result, Q1.15, 0..32767
//   y_pct   out  8  crisp result in percent, 0..100
//   zero_w  out  1  last result came from S_w == 0
// ---------------------------------------------------------------------------
module defuzzifier_div (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] S_w,
   input  logic [15:0] S_wg,
   output logic        busy,
   output logic        done,
   output logic [15:0] y_q15,
   output logic [7:0]  y_pct,
   output logic        zero_w
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_DIV  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q,   cnt_d;
   logic [16:0] rem_q,   rem_d;
   logic [15:0] quo_q,   quo_d;
   logic [15:0] div_q,   div_d;
   logic        zero_q,  zero_d;   // latched S_w == 0
   logic        sat_q,   sat_d;    // latched S_wg >= S_w (S_w != 0)
   logic        done_q,  done_d;
   logic [15:0] y_q,     y_d;
   logic [7:0]  pct_q,   pct_d;
   logic        zw_q,    zw_d;

   // Datapath
   logic [16:0] rem_sh;
   logic [16:0] rem_sub;
   logic        fits;
   logic [16:0] round17;
   logic [15:0] y_norm;
   logic [15:0] y_res;
   logic [22:0] pct_prod;
   logic [22:0] pct_sh;
   logic [7:0]  pct_res;

   always_comb begin
      // rem_q < div_q always holds, so the MSB shifted out is always 0.
      rem_sh  = rem_q << 1;
      fits    = (rem_sh >= {1'b0, div_q});
      rem_sub = rem_sh - {1'b0, div_q};

      round17 = ({1'b0, quo_q} + 17'd1) >> 1;
      y_norm  = (round17 > 17'd32767) ? 16'd32767 : round17[15:0];

      if (zero_q)
         y_res = '0;
      else if (sat_q)
         y_res = 16'd32767;
      else
         y_res = y_norm;

      pct_prod = ({7'd0, y_res} * 23'd100) + 23'd16384;
      pct_sh   = pct_prod >> 15;
      pct_res  = (pct_sh > 23'd100) ? 8'd100 : pct_sh[7:0];
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      div_d   = div_q;
      zero_d  = zero_q;
      sat_d   = sat_q;
      done_d  = 1'b0;
      y_d     = y_q;
      pct_d   = pct_q;
      zw_d    = zw_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               div_d  = S_w;
               rem_d  = {1'b0, S_wg};
               quo_d  = '0;
               cnt_d  = '0;
               zero_d = (S_w == 16'd0);
               sat_d  = (S_w != 16'd0) && (S_wg >= S_w);
               // Special-case operands skip the iterations entirely.
               if ((S_w == 16'd0) || (S_wg >= S_w))
                  state_d = ST_DONE;
               else
                  state_d = ST_DIV;
            end
         end
         ST_DIV: begin
            rem_d = fits ? rem_sub : rem_sh;
            quo_d = {quo_q[14:0], fits};
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd15)
               state_d = ST_DONE;
         end
         ST_DONE: begin
            done_d  = 1'b1;
            y_d     = y_res;
            pct_d   = pct_res;
            zw_d    = zero_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         div_q   <= '0;
         zero_q  <= 1'b0;
         sat_q   <= 1'b0;
         done_q  <= 1'b0;
         y_q     <= '0;
         pct_q   <= '0;
         zw_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         div_q   <= div_d;
         zero_q  <= zero_d;
         sat_q   <= sat_d;
         done_q  <= done_d;
         y_q     <= y_d;
         pct_q   <= pct_d;
         zw_q    <= zw_d;
      end
   end

   assign busy   = (state_q == ST_DIV);
   assign done   = done_q;
   assign y_q15  = y_q;
   assign y_pct  = pct_q;
   assign zero_w = zw_q;

endmodule

// File: tb/tb_defuzzifier_div.sv
// ---------------------------------------------------------------------------
// tb_defuzzifier_div
//   Directed self-checking bench for defuzzifier_div. Expected results are
//   hand-computed from q16 = floor(S_wg*65536/S_w), y = (q16+1)>>1 and
//   pct = (y*100+16384)>>15.
// ---------------------------------------------------------------------------
module tb_defuzzifier_div;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] S_w;
   logic [15:0] S_wg;
   logic        busy;
   logic        done;
   logic [15:0] y_q15;
   logic [7:0]  y_pct;
   logic        zero_w;

   int n_cmp = 0;
   int n_err = 0;

   defuzzifier_div dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .S_w    (S_w),
      .S_wg   (S_wg),
      .busy   (busy),
      .done   (done),
      .y_q15  (y_q15),
      .y_pct  (y_pct),
      .zero_w (zero_w)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int obs, input int exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   // One division: pulse start, watch until done, then check the result,
   // latency, busy length, output hold and the absence of extra done pulses.
   // With poke set, a start pulse and new operands are applied mid-division.
   task automatic run_op(input logic [15:0] w, input logic [15:0] wg,
                         input int exp_y, input int exp_pct, input int exp_zw,
                         input int exp_lat, input bit poke);
      int cyc, busy_cnt, extra;
      bit overlap, changed, got;
      logic [15:0] y0;
      logic [7:0]  p0;
      logic        z0;
      @(negedge clk);
      S_w = w; S_wg = wg; start = 1'b1;
      y0 = y_q15; p0 = y_pct; z0 = zero_w;
      @(posedge clk);
      #1 start = 1'b0;
      cyc = 0; busy_cnt = 0; overlap = 0; changed = 0; got = 0;
      while (cyc < 40) begin
         @(negedge clk);
         if (busy && done) overlap = 1;
         if (busy) busy_cnt++;
         if (done) begin
            got = 1;
            break;
         end
         if (y_q15 !== y0 || y_pct !== p0 || zero_w !== z0) changed = 1;
         if (poke) begin
            start = (cyc == 5);
            if (cyc == 5) begin
               S_w = 16'd3; S_wg = 16'd1;
            end
         end
         @(posedge clk);
         cyc++;
      end
      start = 1'b0;
      chk("done_seen", int'(got), 1);
      chk("latency", cyc, exp_lat);
      chk("busy_cycles", busy_cnt, (exp_lat == 17) ? 16 : 0);
      chk("busy_done_overlap", int'(overlap), 0);
      chk("hold_before_done", int'(changed), 0);
      chk("y_q15", int'(y_q15), exp_y);
      chk("y_pct", int'(y_pct), exp_pct);
      chk("zero_w", int'(zero_w), exp_zw);
      extra = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) extra++;
      end
      chk("extra_done", extra, 0);
      chk("y_q15_hold_after", int'(y_q15), exp_y);
   endtask

   initial begin
      int cyc, first, second, extra;
      rst = 1'b1; start = 1'b0; S_w = '0; S_wg = '0;
      @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_y", int'(y_q15), 0);
      chk("rst_pct", int'(y_pct), 0);
      chk("rst_zw", int'(zero_w), 0);
      @(negedge clk);
      rst = 1'b0;

      run_op(16'd20000, 16'd10000, 16384,  50, 0, 17, 0);
      run_op(16'd3,     16'd1,     10923,  33, 0, 17, 0);
      run_op(16'd0,     16'd500,       0,   0, 1,  1, 0);
      run_op(16'd20000, 16'd10000, 16384,  50, 0, 17, 0);
      run_op(16'd1000,  16'd1000,  32767, 100, 0,  1, 0);
      run_op(16'd100,   16'd32767, 32767, 100, 0,  1, 0);
      run_op(16'd32767, 16'd32766, 32767, 100, 0, 17, 0);
      run_op(16'd100,   16'd1,       328,   1, 0, 17, 0);
      run_op(16'd32767, 16'd1,         1,   0, 0, 17, 0);
      run_op(16'd20000, 16'd10000, 16384,  50, 0, 17, 1);

      // Abort at iteration 8 with an asynchronous reset.
      @(negedge clk);
      S_w = 16'd20000; S_wg = 16'd10000; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (8) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_y", int'(y_q15), 0);
      chk("abort_pct", int'(y_pct), 0);
      chk("abort_zw", int'(zero_w), 0);
      @(negedge clk);
      rst = 1'b0;
      extra = 0;
      repeat (25) begin
         @(negedge clk);
         if (done) extra++;
      end
      chk("abort_no_done", extra, 0);
      run_op(16'd20000, 16'd5000, 8192, 25, 0, 17, 0);

      // start held high: the next division begins right after DONE.
      @(negedge clk);
      S_w = 16'd100; S_wg = 16'd1; start = 1'b1;
      cyc = 0; first = -1; second = -1;
      while (cyc < 60 && second < 0) begin
         @(negedge clk);
         if (done) begin
            if (first < 0) first = cyc;
            else second = cyc;
         end
         cyc++;
      end
      start = 1'b0;
      chk("held_first", first, 17);
      chk("held_gap", second - first, 18);
      chk("held_y", int'(y_q15), 328);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/defuzzifier_div.md
DEFUZZIFIER_DIV -- requirements
Module: defuzzifier_div

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; all ports are as follows.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 S_w  input  16  sum of rule weights, Q1.15 unsigned, 0..32767, from the aggregator stage.
REQ-006 S_wg  input  16  weighted sum, Q1.15 unsigned, 0..32767, from the aggregator stage.
REQ-007 busy  output  1  high while a division is in progress (state DIV).
REQ-008 done  output  1  registered one-cycle pulse: y_q15, y_pct and zero_w are valid and updated.
REQ-009 y_q15  output  16  crisp output S_wg/S_w, Q1.15, 0..32767.
REQ-010 y_pct  output  8  crisp output in percent, 0..100.
REQ-011 zero_w  output  1  high when the last result came from S_w == 0; held until the next done.

Function
REQ-012 State machine SHALL have states IDLE, DIV and DONE; IDLE -> DIV on start with normal operands; IDLE -> DONE on start with special-case operands; DIV -> DONE after 16 iterations; DONE -> IDLE unconditionally.
REQ-013 On the edge that accepts start (edge k), S_w and S_wg SHALL be latched internally; later input changes SHALL NOT affect the running result.
REQ-014 Special case S_w == 0: y_q15 = 0, y_pct = 0, zero_w = 1; results registered and done high after edge k+1.
REQ-015 Special case S_w != 0 and S_wg >= S_w: y_q15 = 32767, y_pct = 100, zero_w = 0; results registered and done high after edge k+1.
REQ-016 Normal case (0 < S_w, S_wg < S_w): restoring division, 1 quotient bit per cycle, 16 bits total, MSB first, 17-bit remainder; q16 = floor(S_wg*65536/S_w).
REQ-017 Rounding SHALL be y_q15 = (q16 + 1) >> 1, then clamped to 32767.
REQ-018 Percent conversion SHALL be y_pct = (y_q15*100 + 16384) >> 15, computed with at least a 23-bit intermediate, then clamped to 100.
REQ-019 Normal-case latency: busy high from edge k to edge k+16; results registered and done high after edge k+17, for exactly one cycle.
REQ-020 start asserted while in DIV or DONE SHALL be ignored, with no queuing.
REQ-021 start held high continuously SHALL begin a new division on the first IDLE cycle after DONE.
REQ-022 y_q15, y_pct and zero_w SHALL change only on the edge that raises done, and hold otherwise.
REQ-023 done and busy SHALL never be high in the same cycle.

Reset
REQ-024 rst high SHALL asynchronously force state IDLE and busy = 0, done = 0, y_q15 = 0, y_pct = 0, zero_w = 0, and clear the counter, remainder and quotient.
REQ-025 rst asserted mid-division SHALL abort it with no done pulse; the first start after rst deasserts SHALL run a fresh division.

Verification
REQ-026 S_w=20000, S_wg=10000, start pulse -> busy for 16 cycles, done 17 cycles after accept, y_q15=16384, y_pct=50, zero_w=0.
REQ-027 S_w=3, S_wg=1 -> q16=21845, y_q15=10923, y_pct=33 (rounding check).
REQ-028 S_w=0, S_wg=500 -> done 1 cycle after accept, y_q15=0, y_pct=0, zero_w=1, busy never high; a following normal run clears zero_w.
REQ-029 S_w=1000, S_wg=1000 and S_w=100, S_wg=32767 -> y_q15=32767, y_pct=100, 1-cycle latency.
REQ-030 Start pulse mid-division plus input changes during DIV -> ignored; the result matches the originally latched operands; exactly one done pulse.
REQ-031 rst pulse at iteration 8 -> all outputs 0 immediately, no done pulse; the next start with S_w=20000, S_wg=5000 -> y_q15=8192, y_pct=25.
